// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data-memory port between the
// pipeline (R0) and the interrupt context sequencer (R1), with R1 burst lock.
module dmem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] Wdata0,
    output logic              Gnt0,
    input  logic              Req1,
    input  logic              We1,
    input  logic              Burst1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Wdata1,
    output logic              Gnt1,
    output logic [DATA_W-1:0] Rdata,
    output logic              Rvalid0,
    output logic              Rvalid1,
    output logic              MemeWrite,
    output logic              MemeRead,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemDataIn,
    input  logic [DATA_W-1:0] MemDataOut
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic   last;
    logic   own1;
    // last=1 means R1 was granted most recently, so R0 wins the next tie
    always_comb begin
        Gnt0     = Rst && state == IDLE && Req0 && (!Req1 || last);
        Gnt1     = Rst && Req1 && (state == BURST || !Req0 || !last);
        state_nx = state;
        if (Gnt1) state_nx = (state == IDLE && Burst1) ? BURST : IDLE;
    end
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            own1      <= 1'b0;
            MemeWrite <= 1'b0;
            MemeRead  <= 1'b0;
            MemAddr   <= '0;
            MemDataIn <= '0;
            Rdata     <= '0;
            Rvalid0   <= 1'b0;
            Rvalid1   <= 1'b0;
        end else begin
            state     <= state_nx;
            MemeWrite <= (Gnt0 && We0) || (Gnt1 && We1);
            MemeRead  <= (Gnt0 && !We0) || (Gnt1 && !We1);
            if (Gnt0 || Gnt1) begin
                last      <= Gnt1;
                own1      <= Gnt1;
                MemAddr   <= Gnt1 ? Addr1 : Addr0;
                MemDataIn <= Gnt1 ? Wdata1 : Wdata0;
            end
            // read data is combinational from memory during the command cycle
            if (MemeRead) Rdata <= MemDataOut;
            Rvalid0 <= MemeRead && !own1;
            Rvalid1 <= MemeRead && own1;
        end
    end
endmodule
